sel5_rr_sched: RTL and testbench
================================

SEL5_RR_SCHED -- requirements
Module: sel5_rr_sched

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop depth of each async-input synchronizer, legal values 2..4.
REQ-002 Parameter SETUP_CYCLES, default 2: clocks o_valid is held stable before o_drive, legal values 1..15.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: wait limit per handshake phase, legal values 1..65535; used only with SEL5_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_req  in  5  requester i request level; held until the matching o_done.
REQ-007 o_done  out  5  one-clock completion pulse to the granted requester.
REQ-008 o_valid  out  5  one-hot select to the 5-way selector valid0..valid4; stable for the whole transaction.
REQ-009 o_drive  out  1  one-clock launch pulse to the selector i_drive.
REQ-010 i_fire  in  1  async selector fire (o_fire_2[1]), pulse width at least SYNC_STAGES+1 clocks.
REQ-011 i_free_next  in  1  async OR of downstream freeNext0..4, same pulse-width rule.
REQ-012 o_grant_id  out  3  index 0..4 of the current winner; 0 when idle.
REQ-013 o_busy  out  1  high in every state except IDLE.
REQ-014 o_timeout  out  1  sticky timeout flag.

Function
REQ-015 FSM states: IDLE, SETUP, WAIT_FIRE, WAIT_DONE.
REQ-016 IDLE with i_req nonzero: round-robin winner, searched from last_winner+1 modulo 5; load o_valid one-hot and o_grant_id; go to SETUP.
REQ-017 IDLE with i_req zero: stay in IDLE, o_valid=0.
REQ-018 SETUP: hold o_valid for SETUP_CYCLES clocks, then assert o_drive for exactly 1 clock and enter WAIT_FIRE in the same cycle.
REQ-019 WAIT_FIRE: exit on the synchronized rising edge of i_fire to WAIT_DONE.
REQ-020 WAIT_DONE: on the synchronized rising edge of i_free_next, pulse o_done[winner] for 1 clock, set last_winner=winner, clear o_valid, return to IDLE.
REQ-021 Minimum cycles from IDLE grant to next IDLE: SETUP_CYCLES+2 plus synchronizer latency (SYNC_STAGES+1 per edge).
REQ-022 i_fire or i_free_next edges arriving in a state that does not expect them are ignored; they do not queue.
REQ-023 i_fire and i_free_next edges in the same cycle in WAIT_FIRE: take the fire edge only; the free edge is lost.
REQ-024 Deasserting i_req mid-transaction: no effect; the transaction completes and o_done still pulses.
REQ-025 o_valid changes only on entry to SETUP and on exit from WAIT_DONE, never while o_drive or a fire is in flight.
REQ-026 At most one o_valid bit and at most one o_done bit are high at any time.

Reset
REQ-027 On rst: state=IDLE; o_valid, o_done, o_drive, o_busy, o_timeout=0; o_grant_id=0; last_winner=4 (so requester 0 has priority first); synchronizers and counters cleared.
REQ-028 rst mid-transaction aborts it with no o_done; the bench re-resets the selector alongside.

Configuration
REQ-029 Macro SEL5_TIMEOUT_EN defined: a 16-bit counter runs in WAIT_FIRE and WAIT_DONE; on reaching TIMEOUT_CYCLES, set o_timeout, clear o_valid, set last_winner=winner, go to IDLE, no o_done.
REQ-030 o_timeout clears only on rst.
REQ-031 Macro SEL5_TIMEOUT_EN absent: no counter; the FSM waits indefinitely; o_timeout is tied to 0.

Structure
REQ-032 Package sel5_pkg holds: state enum, N_REQ=5, ID_W=3, one-hot/index conversion function.
REQ-033 Sub-module sel5_sync_edge: SYNC_STAGES-deep synchronizer plus rising-edge detector; instantiated for i_fire and i_free_next.

Verification
REQ-034 Single request i_req=00100 -> o_valid=00100 for SETUP_CYCLES clocks, then o_drive pulse; fire, then free -> o_done=00100, o_grant_id=2.
REQ-035 All i_req=11111 held, 6 transactions after reset -> grant order 0,1,2,3,4,0.
REQ-036 i_req=10001 with last_winner=0 -> grant 4, then 0.
REQ-037 Fire and free edges injected in IDLE -> no state change, no o_done.
REQ-038 With SEL5_TIMEOUT_EN, TIMEOUT_CYCLES=10, no i_fire -> o_timeout=1 ten clocks after o_drive, back in IDLE; without the macro -> remains in WAIT_FIRE.
REQ-039 rst asserted in WAIT_DONE -> all outputs 0 immediately (asynchronous); next grant is requester 0.

Source files
------------

// File: rtl/sel5_pkg.sv
// -----------------------------------------------------------------------------
// sel5_pkg
// Shared definitions for the five-way round-robin selector scheduler:
//   N_REQ         number of requesters
//   ID_W          width of a requester index
//   sel5_state_e  scheduler FSM state encoding
//   id_to_onehot  requester index -> one-hot select vector
// -----------------------------------------------------------------------------
package sel5_pkg;

    localparam int N_REQ = 5;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SETUP     = 2'd1,
        ST_WAIT_FIRE = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sel5_state_e;

    // Indices outside 0..N_REQ-1 map to an all-zero vector.
    function automatic logic [N_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        if (int'(id) < N_REQ) begin
            v[id] = 1'b1;
        end else begin
            v = {N_REQ{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/sel5_sync_edge.sv
// -----------------------------------------------------------------------------
// sel5_sync_edge
// Multi-flop synchronizer for an asynchronous level followed by a rising-edge
// detector. The input must stay high for at least SYNC_STAGES+1 clocks so the
// edge is never missed.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   i_async  asynchronous input level
//   o_rise   one-clock pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module sel5_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus one delayed copy of its output for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Decoded purely from flops, so it is glitch-free for the consuming FSM;
    // total edge latency is SYNC_STAGES+1 clocks.
    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/sel5_rr_sched.sv
// -----------------------------------------------------------------------------
// sel5_rr_sched
// Round-robin scheduler driving a five-way selector. It picks one requester,
// holds its one-hot select stable for SETUP_CYCLES clocks, launches the
// selector with a one-clock o_drive pulse, then waits for the synchronized
// selector fire edge and the downstream free edge before pulsing o_done.
// Optional feature: define SEL5_TIMEOUT_EN to abort a handshake phase that
// waits TIMEOUT_CYCLES clocks; the sticky o_timeout flag then records it.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_req[5]     request levels, held until the matching o_done
//   o_done[5]    one-clock completion pulse to the granted requester
//   o_valid[5]   one-hot selector select, stable for the whole transaction
//   o_drive      one-clock selector launch pulse
//   i_fire       asynchronous selector fire level
//   i_free_next  asynchronous downstream free level
//   o_grant_id   index of the current winner, 0 when idle
//   o_busy       high whenever the FSM is not idle
//   o_timeout    sticky timeout flag (0 unless SEL5_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module sel5_rr_sched
    import sel5_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_valid,
    output logic             o_drive,
    input  logic             i_fire,
    input  logic             i_free_next,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_busy,
    output logic             o_timeout
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || SETUP_CYCLES < 1 || SETUP_CYCLES > 15 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("sel5_rr_sched: parameter out of legal range");
    end

    sel5_state_e      r_state;
    logic [N_REQ-1:0] r_valid;
    logic [N_REQ-1:0] r_done;
    logic             r_drive;
    logic [ID_W-1:0]  r_grant_id;
    logic [ID_W-1:0]  r_last;
    logic             r_busy;
    logic [3:0]       r_setup_cnt;

    logic             w_fire_rise;
    logic             w_free_rise;
    logic             w_tmo_hit;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_cand;

    sel5_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fire (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_fire),
        .o_rise  (w_fire_rise)
    );

    sel5_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_free (
        .clk     (clk),
        .rst     (rst),
        .i_async (i_free_next),
        .o_rise  (w_free_rise)
    );

    // Round-robin search: walk candidates from farthest to nearest after
    // r_last so the nearest requesting index overwrites the others.
    always_comb begin
        w_winner = r_last;
        w_cand   = {ID_W{1'b0}};
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand   = ID_W'((32'(r_last) + 32'(k)) % 32'(N_REQ));
            w_winner = i_req[w_cand] ? w_cand : w_winner;
        end
    end

`ifdef SEL5_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_timeout;

    // Per-phase wait counter; restarts when a phase ends, frozen at zero outside the waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= 16'd0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_FIRE: begin
                    r_tmo_cnt <= w_fire_rise ? 16'd0 : r_tmo_cnt + 16'd1;
                    r_timeout <= r_timeout | (w_tmo_hit & ~w_fire_rise);
                end
                ST_WAIT_DONE: begin
                    r_tmo_cnt <= w_free_rise ? 16'd0 : r_tmo_cnt + 16'd1;
                    r_timeout <= r_timeout | (w_tmo_hit & ~w_free_rise);
                end
                default: begin
                    r_tmo_cnt <= 16'd0;
                    r_timeout <= r_timeout;
                end
            endcase
        end
    end

    assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign o_timeout = r_timeout;
`else
    assign w_tmo_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Scheduler FSM; o_done and o_drive default low so they pulse for one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_valid     <= {N_REQ{1'b0}};
            r_done      <= {N_REQ{1'b0}};
            r_drive     <= 1'b0;
            r_grant_id  <= {ID_W{1'b0}};
            r_last      <= 3'd4;
            r_busy      <= 1'b0;
            r_setup_cnt <= 4'd0;
        end else begin
            r_done  <= {N_REQ{1'b0}};
            r_drive <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|i_req) begin
                        r_valid     <= id_to_onehot(w_winner);
                        r_grant_id  <= w_winner;
                        r_busy      <= 1'b1;
                        r_setup_cnt <= 4'd0;
                        r_state     <= ST_SETUP;
                    end else begin
                        r_valid    <= {N_REQ{1'b0}};
                        r_grant_id <= {ID_W{1'b0}};
                        r_busy     <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    if (r_setup_cnt == 4'(SETUP_CYCLES - 1)) begin
                        r_drive <= 1'b1;
                        r_state <= ST_WAIT_FIRE;
                    end else begin
                        r_setup_cnt <= r_setup_cnt + 4'd1;
                    end
                end
                // Free edges are deliberately not looked at here: a free edge
                // coincident with the fire edge is dropped, not deferred.
                ST_WAIT_FIRE: begin
                    if (w_fire_rise) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (w_tmo_hit) begin
                        r_valid    <= {N_REQ{1'b0}};
                        r_grant_id <= {ID_W{1'b0}};
                        r_last     <= r_grant_id;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_FIRE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_free_rise) begin
                        r_done     <= r_valid;
                        r_valid    <= {N_REQ{1'b0}};
                        r_grant_id <= {ID_W{1'b0}};
                        r_last     <= r_grant_id;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else if (w_tmo_hit) begin
                        r_valid    <= {N_REQ{1'b0}};
                        r_grant_id <= {ID_W{1'b0}};
                        r_last     <= r_grant_id;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                default: begin
                    r_valid    <= {N_REQ{1'b0}};
                    r_grant_id <= {ID_W{1'b0}};
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_done     = r_done;
    assign o_valid    = r_valid;
    assign o_drive    = r_drive;
    assign o_grant_id = r_grant_id;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_sel5_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_sel5_rr_sched
// Self-checking bench for sel5_rr_sched. Expected completions are queued when a
// request is issued; an independent monitor pops them whenever o_done pulses.
// The grant order comes from a round-robin reference written directly from the
// arbitration rule. Build with SEL5_TIMEOUT_EN to exercise the timeout path.
// -----------------------------------------------------------------------------
module tb_sel5_rr_sched;

    localparam int SYNC  = 2;
    localparam int SETUP = 3;
    localparam int TMO   = 10;

    logic       clk;
    logic       rst;
    logic [4:0] i_req;
    logic       i_fire;
    logic       i_free_next;
    logic [4:0] o_done;
    logic [4:0] o_valid;
    logic       o_drive;
    logic [2:0] o_grant_id;
    logic       o_busy;
    logic       o_timeout;

    int         total = 0;
    int         bad   = 0;
    int         m_last = 4;
    int         m_pending = 0;
    int         exp_to = 0;
    logic [4:0] q_done[$];

    sel5_rr_sched #(
        .SYNC_STAGES    (SYNC),
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .o_done      (o_done),
        .o_valid     (o_valid),
        .o_drive     (o_drive),
        .i_fire      (i_fire),
        .i_free_next (i_free_next),
        .o_grant_id  (o_grant_id),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first requester found walking forward from last winner.
    function automatic int rr_pick(input int last, input logic [4:0] req);
        for (int k = 1; k <= 5; k++) begin
            automatic int c = (last + k) % 5;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [4:0] oh(input int i);
        logic [4:0] v;
        v = 5'd1 << i;
        return v;
    endfunction

    // Monitor: every o_done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && o_done != 5'd0) begin
            if (q_done.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got %b expected none", o_done);
            end else begin
                e = q_done.pop_front();
                chk("done_vec", int'(o_done), int'(e));
            end
        end
        if (!rst) begin
            chk("valid_onehot0", int'($countones(o_valid) <= 1), 1);
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(o_valid), 0);
        chk({tag, "_done"},  int'(o_done), 0);
        chk({tag, "_drive"}, int'(o_drive), 0);
        chk({tag, "_busy"},  int'(o_busy), 0);
        chk({tag, "_gid"},   int'(o_grant_id), 0);
        chk({tag, "_tmo"},   int'(o_timeout), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        i_req = 5'd0; i_fire = 1'b0; i_free_next = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        m_last = 4;
        exp_to = 0;
    endtask

    // Issue a request from idle and follow it through setup up to the drive pulse.
    task automatic start_txn(input logic [4:0] req, output int gid);
        int w, n;
        logic [4:0] v;
        w = rr_pick(m_last, req);
        v = oh(w);
        i_req = req;
        q_done.push_back(v);
        @(negedge clk);
        chk("busy_on_grant", int'(o_busy), 1);
        chk("grant_id", int'(o_grant_id), w);
        chk("valid_load", int'(o_valid), int'(v));
        chk("timeout_flag", int'(o_timeout), exp_to);
        gid = int'(o_grant_id);
        n = 0;
        while (!o_drive && n < 40) begin
            chk("valid_hold", int'(o_valid), int'(v));
            @(negedge clk);
            n++;
        end
        chk("setup_len", n, SETUP);
        chk("valid_at_drive", int'(o_valid), int'(v));
        m_pending = w;
    endtask

    // Fire then free handshake; dual also raises free together with fire (that free is lost).
    task automatic finish_txn(input bit dual);
        int wf, g, n;
        wf = $urandom_range(SYNC + 2, SYNC + 1);
        i_fire = 1'b1;
        if (dual) i_free_next = 1'b1;
        @(negedge clk);
        chk("drive_pulse", int'(o_drive), 0);
        repeat (wf - 1) @(negedge clk);
        i_fire = 1'b0;
        i_free_next = 1'b0;
        chk("busy_after_fire", int'(o_busy), 1);
        g = dual ? int'($urandom_range(SYNC + 2, SYNC + 1)) : int'($urandom_range(2, 1));
        repeat (g) @(negedge clk);
        chk("busy_before_free", int'(o_busy), 1);
        chk("valid_before_free", int'(o_valid), int'(oh(m_pending)));
        i_free_next = 1'b1;
        n = 0;
        while (o_busy && n < 40) begin
            @(negedge clk);
            n++;
            if (n == SYNC + 1) i_free_next = 1'b0;
        end
        i_free_next = 1'b0;
        i_req = 5'd0;
        chk("free_latency", n, SYNC + 1);
        chk("valid_cleared", int'(o_valid), 0);
        chk("gid_idle", int'(o_grant_id), 0);
        m_last = m_pending;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gid, n;
        int order_all [6] = '{0, 1, 2, 3, 4, 0};
        rst = 1'b1;
        i_req = 5'd0; i_fire = 1'b0; i_free_next = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("por");
        rst = 1'b0;

        // Single requester 2.
        start_txn(5'b00100, gid);
        chk("single_gid", gid, 2);
        finish_txn(1'b0);

        // All requesting after reset: strict rotation from requester 0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            start_txn(5'b11111, gid);
            chk("rr_all", gid, order_all[i]);
            finish_txn(1'b0);
        end

        // Last winner 0, requesters 0 and 4: 4 goes first.
        start_txn(5'b10001, gid);
        chk("rr_10001_a", gid, 4);
        finish_txn(1'b1);
        start_txn(5'b10001, gid);
        chk("rr_10001_b", gid, 0);
        finish_txn(1'b0);

        // Fire / free edges while idle must not start anything.
        for (int p = 0; p < 3; p++) begin
            i_fire = (p != 1);
            i_free_next = (p != 0);
            for (int c = 0; c < 2 * SYNC + 4; c++) begin
                @(negedge clk);
                if (c == SYNC + 1) begin
                    i_fire = 1'b0;
                    i_free_next = 1'b0;
                end
                chk("idle_busy", int'(o_busy), 0);
                chk("idle_valid", int'(o_valid), 0);
            end
        end

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            logic [4:0] req;
            req = 5'($urandom_range(31, 1));
            if ($urandom_range(2, 0) == 0) repeat ($urandom_range(4, 1)) @(negedge clk);
            start_txn(req, gid);
            if ($urandom_range(3, 0) == 0) i_req = 5'd0;
            finish_txn(1'($urandom_range(1, 0)));
        end

        // No fire after the drive pulse.
        start_txn(5'b00010, gid);
`ifdef SEL5_TIMEOUT_EN
        void'(q_done.pop_back());
        n = 0;
        while (!o_timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        i_req = 5'd0;
        chk("timeout_latency", n, TMO);
        chk("timeout_idle", int'(o_busy), 0);
        chk("timeout_valid", int'(o_valid), 0);
        exp_to = 1;
        m_last = m_pending;
        repeat (3) @(negedge clk);
        chk("timeout_sticky", int'(o_timeout), 1);
`else
        repeat (30) @(negedge clk);
        chk("wait_forever_busy", int'(o_busy), 1);
        chk("wait_forever_valid", int'(o_valid), int'(oh(m_pending)));
        chk("wait_forever_tmo", int'(o_timeout), 0);
        finish_txn(1'b0);
`endif

        // Reset while waiting for free: asynchronous clear, no o_done, priority restarts at 0.
        start_txn(5'b01000, gid);
        i_fire = 1'b1;
        repeat (SYNC + 2) @(negedge clk);
        i_fire = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", int'(o_busy), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        void'(q_done.pop_back());
        i_req = 5'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 4;
        exp_to = 0;
        start_txn(5'b11111, gid);
        chk("post_reset_gid", gid, 0);
        finish_txn(1'b0);

        repeat (4) @(negedge clk);
        chk("queue_empty", q_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
